// File: rtl/sim_check_pkg.sv
// rtl/sim_check_pkg.sv - shared types and defaults for the end-of-test register check monitor
package sim_check_pkg;

  localparam int          XLEN_DEFAULT        = 32;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FF0;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_RUN   = 2'd1,
    MON_CHECK = 2'd2,
    MON_DONE  = 2'd3
  } mon_state_t;

  typedef struct packed {
    logic                    valid;
    logic [4:0]              rg;
    logic [XLEN_DEFAULT-1:0] val;
  } exp_entry_t;

endpackage

// File: rtl/shadow_regfile.sv
// rtl/shadow_regfile.sv - 32-entry shadow of the CPU register file, x0 hard-wired to zero
module shadow_regfile #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  input  logic            i_clr,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [4:0]      i_ra,
  output logic [XLEN-1:0] o_rd
);

  logic [XLEN-1:0] r_regs [32];

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd = (i_ra == 5'd0) ? '0 : r_regs[i_ra];

endmodule

// File: rtl/reg_check_monitor.sv
// rtl/reg_check_monitor.sv - snoops writeback into a shadow regfile, detects halt/timeout,
// then walks the expectation table one slot per cycle and reports pass/fail.
module reg_check_monitor
  import sim_check_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              NUM_CHECKS     = 16,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(TOHOST_ADDR_DEFAULT),
  parameter int              IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  parameter int              CNT_W          = $clog2(NUM_CHECKS + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             mem_wr_en,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_data_in,
  input  logic             exp_wr,
  input  logic [IDX_W-1:0] exp_idx,
  input  logic             exp_valid,
  input  logic [4:0]       exp_reg,
  input  logic [XLEN-1:0]  exp_val,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic [XLEN-1:0]  halt_code,
  output logic [CNT_W-1:0] fail_count,
  output logic [IDX_W-1:0] first_fail_idx
);

  localparam int               TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam int               SLOTS    = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

  mon_state_t       r_state, w_next;
  logic [TW-1:0]    r_cycles;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_fail_count;
  logic [IDX_W-1:0] r_first_fail_idx;
  logic             r_timed_out;
  logic [XLEN-1:0]  r_halt_code;

  logic [SLOTS-1:0] r_tbl_valid;
  logic [4:0]       r_tbl_reg [SLOTS];
  logic [XLEN-1:0]  r_tbl_val [SLOTS];

  logic            w_accept, w_start, w_halt, w_timeout, w_mismatch, w_tbl_we;
  logic [XLEN-1:0] w_rd_data;

  assign w_accept   = (r_state == MON_IDLE) || (r_state == MON_DONE);
  assign w_start    = start && w_accept;
  assign w_halt     = (r_state == MON_RUN) && mem_wr_en && (mem_addr == TOHOST_ADDR);
  assign w_timeout  = (r_state == MON_RUN) && !w_halt && (r_cycles == TO_LAST);
  assign w_tbl_we   = exp_wr && w_accept && (exp_idx <= LAST_IDX);
  assign w_mismatch = (r_state == MON_CHECK) && r_tbl_valid[r_idx] &&
                      (w_rd_data != r_tbl_val[r_idx]);

  shadow_regfile #(.XLEN(XLEN)) u_shadow (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_clr    (w_start),
    .i_we     ((r_state == MON_RUN) && wb_en),
    .i_wa     (wb_rd),
    .i_wd     (wb_data),
    .i_ra     (r_tbl_reg[r_idx]),
    .o_rd     (w_rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= MON_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MON_IDLE:  if (start) w_next = MON_RUN;
      MON_RUN:   if (w_halt || w_timeout) w_next = MON_CHECK;
      MON_CHECK: if (r_idx == LAST_IDX) w_next = MON_DONE;
      MON_DONE:  if (start) w_next = MON_RUN;
      default:   w_next = MON_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cycles         <= '0;
      r_idx            <= '0;
      r_fail_count     <= '0;
      r_first_fail_idx <= '0;
      r_timed_out      <= 1'b0;
      r_halt_code      <= '0;
    end else if (w_start) begin
      r_cycles         <= '0;
      r_idx            <= '0;
      r_fail_count     <= '0;
      r_first_fail_idx <= '0;
      r_timed_out      <= 1'b0;
      r_halt_code      <= '0;
    end else if (r_state == MON_RUN) begin
      r_cycles <= r_cycles + TW'(1);
      r_idx    <= '0;
      // a tohost store on the timeout cycle takes priority over the timeout
      if (w_halt) begin
        r_halt_code <= mem_data_in;
      end else if (w_timeout) begin
        r_timed_out <= 1'b1;
        r_halt_code <= '0;
      end
    end else if (r_state == MON_CHECK) begin
      r_idx <= r_idx + IDX_W'(1);
      if (w_mismatch) begin
        r_fail_count <= r_fail_count + CNT_W'(1);
        if (r_fail_count == '0) r_first_fail_idx <= r_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_tbl_valid <= '0;
    else if (w_tbl_we) r_tbl_valid[exp_idx] <= exp_valid;
  end

  // Register/value fields need no reset: they are only read under a set valid bit.
  always_ff @(posedge clk) begin
    if (w_tbl_we) begin
      r_tbl_reg[exp_idx] <= exp_reg;
      r_tbl_val[exp_idx] <= exp_val;
    end
  end

  assign busy           = (r_state == MON_RUN) || (r_state == MON_CHECK);
  assign done           = (r_state == MON_DONE);
  assign pass           = done && (r_fail_count == '0) && !r_timed_out;
  assign timed_out      = r_timed_out;
  assign halt_code      = r_halt_code;
  assign fail_count     = r_fail_count;
  assign first_fail_idx = r_first_fail_idx;

endmodule

// File: doc/reg_check_monitor.md
Name: reg_check_monitor

Overview:
Parametrised, self-checking end-of-test monitor for CPU instruction tests. It snoops the writeback port to keep a shadow register file. It detects program halt, either a store to a tohost address or a cycle timeout. It then compares up to NUM_CHECKS loaded expectations against the shadow registers, one per cycle, and reports pass/fail. This replaces hand-written per-register assertions in each instruction testbench; the monitor sits beside cpu and data_memory in the bench.

Parameters:
XLEN, 32, register/data width
NUM_CHECKS, 16, expectation table depth
TIMEOUT_CYCLES, 1000, RUN cycles before forced halt (>=1)
TOHOST_ADDR, 32'h0000_0FF0, store address that signals halt
IDX_W, $clog2(NUM_CHECKS), table index width (derived; 1 if NUM_CHECKS==1)
CNT_W, $clog2(NUM_CHECKS+1), fail counter width (derived)

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
wb_en  in  1  writeback valid
wb_rd  in  5  writeback destination register
wb_data  in  XLEN  writeback value
mem_wr_en  in  1  data-memory write strobe
mem_addr  in  XLEN  data-memory address
mem_data_in  in  XLEN  data-memory store data
exp_wr  in  1  expectation table write
exp_idx  in  IDX_W  table slot
exp_valid  in  1  slot enable
exp_reg  in  5  register to check
exp_val  in  XLEN  expected value
busy  out  1  state is RUN or CHECK
done  out  1  state is DONE
pass  out  1  valid when done
timed_out  out  1  halt caused by timeout
halt_code  out  XLEN  data of the tohost store (0 on timeout)
fail_count  out  CNT_W  number of mismatching valid entries
first_fail_idx  out  IDX_W  slot of the first mismatch (0 if none)

Behaviour:
- Reset (async, resetn=0) sets:
  - state=IDLE; all outputs 0.
  - Shadow regs all 0; table valid bits all 0; cycle counter 0.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> CHECK on halt or timeout.
  - CHECK -> DONE after index NUM_CHECKS-1.
  - DONE -> RUN on start.
- start:
  - In IDLE or DONE: clears shadow regs, cycle counter, fail_count, first_fail_idx, timed_out and halt_code. The table is kept.
  - Ignored in RUN and CHECK.
- Expectation table:
  - exp_wr accepted only in IDLE or DONE and written at the clock edge; ignored in RUN and CHECK.
  - Rewriting a slot overwrites it.
- Shadow register file:
  - In RUN, wb_en with wb_rd!=0 writes wb_data at the clock edge.
  - Writes to x0 are discarded; x0 always reads 0.
  - Writebacks outside RUN are ignored.
- Halt:
  - In RUN, mem_wr_en && mem_addr==TOHOST_ADDR -> capture halt_code=mem_data_in and go to CHECK next cycle.
  - A writeback in the same cycle as the halt store is still applied.
- Timeout:
  - The cycle counter increments each RUN cycle.
  - When the counter == TIMEOUT_CYCLES-1 and no halt occurs that cycle: timed_out=1, halt_code=0, go to CHECK.
  - Halt and timeout in the same cycle: halt wins, timed_out=0.
- CHECK:
  - The index steps 0..NUM_CHECKS-1, one slot per cycle; latency is fixed at NUM_CHECKS cycles.
  - Valid slot with shadow[exp_reg]!=exp_val: fail_count+1 (cannot overflow by width choice). On the first mismatch, first_fail_idx=index.
  - Invalid slots are skipped but still consume their cycle.
- DONE:
  - done=1 and pass=(fail_count==0 && !timed_out).
  - Outputs hold until the next start or reset.
- Reset mid-RUN or mid-CHECK aborts immediately to the reset state; the table is cleared.

Decomposition:
- Package sim_check_pkg:
  - mon_state_t enum {MON_IDLE, MON_RUN, MON_CHECK, MON_DONE}.
  - exp_entry_t packed struct {valid, reg[4:0], val[XLEN-1:0]}.
  - Default TOHOST_ADDR localparam.
- Sub-module shadow_regfile (32 x XLEN):
  - One write port with x0 discard and synchronous clear.
  - One combinational read port used by CHECK.

Test Plan:
1. Basic pass:
   - Stimulus: load slots 0-3 = {x10=1, x11=32'h8000_0000, x12=301, x19=99}; start; drive those writebacks; store 1 to 0x0FF0.
   - Required: done after 16 CHECK cycles, pass=1, fail_count=0, halt_code=1.
2. Mismatch:
   - Stimulus: as scenario 1, but x12 is written 300 and slot 5 = {x13=302} is never written.
   - Required: fail_count=2, first_fail_idx=2, pass=0.
3. Timeout:
   - Stimulus: TIMEOUT_CYCLES=20; start; no tohost store.
   - Required: CHECK entered after 20 RUN cycles, timed_out=1, halt_code=0, pass=0 even with all checks matching.
4. x0 and same-cycle events:
   - Stimulus: wb x0=5 (slot x0=0); a wb x14=301 coincident with the halt store; a halt store on the exact timeout cycle.
   - Required: x0 check passes, x14 check passes, timed_out=0.
5. Reset mid-CHECK:
   - Stimulus: resetn=0 asynchronously during CHECK index 3.
   - Required: outputs 0 immediately; a start with an empty table gives pass=1, fail_count=0.
6. Restart:
   - Stimulus: from DONE with fail_count=2, start again with correct values.
   - Required: counters cleared at start; second run gives pass=1. exp_wr pulsed during RUN must have no effect.
